// File: rtl/ifu_axi_fetch.sv
// ---------------------------------------------------------------------------
// ifu_axi_fetch
//   Single-entry instruction fetch unit. Accepts one PC from upstream, reads
//   the instruction word over an AXI4-Lite read channel, and holds the result
//   for the decode stage until it is consumed. Misaligned PCs and bus errors
//   are reported as ERR_INST with fetch_err set. A flush discards whatever is
//   in flight or held; an AXI read that has already started is still carried
//   to completion so the bus is never left with a dangling transaction.
//
// Parameters
//   RESET_CNT : reset value of inst_cnt
//   ERR_INST  : instruction word presented on any fetch error
//
// Ports
//   clk, rst                     : rising-edge clock, async active-high reset
//   s_valid/s_ready, pc          : upstream fetch request
//   flush                        : discard in-flight or held fetch
//   araddr/arvalid/arready       : AXI4-Lite read address channel
//   rdata/rresp/rvalid/rready    : AXI4-Lite read data channel
//   m_valid/m_ready              : downstream (decode) handshake
//   inst, pc_out, fetch_err      : held result
//   inst_cnt                     : completed downstream handshakes (wraps)
// ---------------------------------------------------------------------------
module ifu_axi_fetch #(
  parameter logic [31:0] RESET_CNT = 32'd0,
  parameter logic [31:0] ERR_INST  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] inst,
  output logic [31:0] pc_out,
  output logic        fetch_err,
  output logic [31:0] inst_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t      state, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        flushed_q, flushed_d;   // current AXI read is to be discarded

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pc_q      <= 32'd0;
      inst_q    <= 32'd0;
      err_q     <= 1'b0;
      flushed_q <= 1'b0;
      cnt_q     <= RESET_CNT;
    end else begin
      state     <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      err_q     <= err_d;
      flushed_q <= flushed_d;
      cnt_q     <= cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and next-datapath logic
  // -------------------------------------------------------------------------
  // NOTE: every variable gets its hold value first so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state;
    pc_d      = pc_q;
    inst_d    = inst_q;
    err_d     = err_q;
    flushed_d = flushed_q;
    cnt_d     = cnt_q;

    unique case (state)
      IDLE: begin
        if (s_valid && s_ready) begin
          pc_d = pc;
          if (pc[1:0] == 2'b00) begin
            state_d = AR;
          end else begin
            // Misaligned: answer locally, never touch the bus.
            inst_d  = ERR_INST;
            err_d   = 1'b1;
            state_d = HOLD;
          end
        end
      end

      AR: begin
        // arvalid must stay up until arready even if flushed.
        if (flush)   flushed_d = 1'b1;
        if (arready) state_d   = R;
      end

      R: begin
        if (flush) flushed_d = 1'b1;
        if (rvalid) begin
          if (flushed_q || flush) begin
            // Discarded read: drain it and skip HOLD entirely.
            flushed_d = 1'b0;
            state_d   = IDLE;
          end else begin
            err_d   = (rresp != 2'b00);
            inst_d  = (rresp != 2'b00) ? ERR_INST : rdata;
            state_d = HOLD;
          end
        end
      end

      HOLD: begin
        if (flush || flushed_q) begin
          flushed_d = 1'b0;
          state_d   = IDLE;
        end else if (m_ready) begin
          cnt_d   = cnt_q + 32'd1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // rst is folded in so upstream sees no acceptance while reset is held,
  // even though the state register already reads IDLE.
  assign s_ready   = (state == IDLE) && !flush && !rst;
  assign araddr    = pc_q;
  assign arvalid   = (state == AR);
  assign rready    = (state == R);
  // Gating with flush keeps a same-cycle m_ready from completing a handshake.
  assign m_valid   = (state == HOLD) && !flushed_q && !flush;
  assign inst      = inst_q;
  assign pc_out    = pc_q;
  assign fetch_err = err_q;
  assign inst_cnt  = cnt_q;

endmodule

// File: tb/tb_ifu_axi_fetch.sv
// ---------------------------------------------------------------------------
// tb_ifu_axi_fetch
//   Scoreboard bench for ifu_axi_fetch. Accepted requests push their expected
//   result (computed from the PC and the bus response the bench will return);
//   a monitor pops and compares whenever the DUT presents a result. A second
//   instance with RESET_CNT=32'hFFFF_FFFF shares all inputs and exercises the
//   counter wrap. Directed scenarios run first, then randomized traffic.
// ---------------------------------------------------------------------------
module tb_ifu_axi_fetch;

  localparam logic [31:0] ERR_INST = 32'hDEAD_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic [31:0] pc = 32'd0;
  logic        flush = 1'b0;
  logic        m_ready = 1'b0;
  logic        arready = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = 32'd0;
  logic [1:0]  rresp = 2'b00;

  logic        s_ready, arvalid, rready, m_valid, fetch_err;
  logic [31:0] araddr, inst, pc_out, inst_cnt;
  logic        w_s_ready, w_arvalid, w_rready, w_m_valid, w_fetch_err;
  logic [31:0] w_araddr, w_inst, w_pc_out, w_inst_cnt;

  ifu_axi_fetch #(.RESET_CNT(32'd0), .ERR_INST(ERR_INST)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .pc(pc),
    .flush(flush), .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .m_valid(m_valid), .m_ready(m_ready), .inst(inst), .pc_out(pc_out),
    .fetch_err(fetch_err), .inst_cnt(inst_cnt)
  );

  ifu_axi_fetch #(.RESET_CNT(32'hFFFF_FFFF), .ERR_INST(ERR_INST)) dut_w (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(w_s_ready), .pc(pc),
    .flush(flush), .araddr(w_araddr), .arvalid(w_arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(w_rready),
    .m_valid(w_m_valid), .m_ready(m_ready), .inst(w_inst), .pc_out(w_pc_out),
    .fetch_err(w_fetch_err), .inst_cnt(w_inst_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_cnt = 32'd0;

  // A fetch fails if the PC is not word aligned or the bus answers non-OKAY.
  function automatic exp_t predict(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
    exp_t e;
    e.pc = a;
    if (a[1:0] != 2'b00 || r != 2'b00) begin
      e.inst = ERR_INST;
      e.err  = 1'b1;
    end else begin
      e.inst = d;
      e.err  = 1'b0;
    end
    return e;
  endfunction

  // Bus response chosen for the next request, and the copy locked at acceptance.
  logic [31:0] slave_data = 32'd0;
  logic [1:0]  slave_resp = 2'b00;
  logic [31:0] rd_data = 32'd0;
  logic [1:0]  rd_resp = 2'b00;
  int          ar_wait = 0;
  int          r_wait  = 0;
  bit          rand_mode = 1'b0;

  // Observation counters (read as before/after differences by scenarios).
  int ar_cycles = 0;
  int r_hs_cnt  = 0;
  int mv_cnt    = 0;

  // ---------------- AXI slave ----------------
  int ar_cnt = 0;
  int r_cnt  = 0;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      arready = 1'b0;
      rvalid  = 1'b0;
      ar_cnt  = 0;
      r_cnt   = 0;
    end else begin
      if (arvalid) begin
        arready = (ar_cnt >= ar_wait);
        ar_cnt++;
      end else begin
        arready = 1'b0;
        ar_cnt  = 0;
      end
      if (rready) begin
        rvalid = (r_cnt >= r_wait);
        rdata  = rvalid ? rd_data : 32'd0;
        rresp  = rvalid ? rd_resp : 2'b00;
        r_cnt++;
      end else begin
        rvalid = 1'b0;
        rdata  = 32'd0;
        rresp  = 2'b00;
        r_cnt  = 0;
      end
    end
  end

  // ---------------- issue tracker + AXI protocol checks ----------------
  bit          ar_expected = 1'b0;
  logic [31:0] exp_araddr = 32'd0;
  bit          arv_prev = 1'b0;
  bit          arr_prev = 1'b0;
  logic [31:0] araddr_prev = 32'd0;

  always @(negedge clk) begin
    if (rst) begin
      ar_expected = 1'b0;
      arv_prev    = 1'b0;
      arr_prev    = 1'b0;
    end else begin
      if (arvalid) begin
        ar_cycles++;
        check("arvalid_without_aligned_request", {31'd0, ar_expected}, 32'd1);
        check("araddr", araddr, exp_araddr);
      end
      if (arv_prev && !arr_prev) begin
        check("arvalid_held_until_arready", {31'd0, arvalid}, 32'd1);
        check("araddr_held_until_arready", araddr, araddr_prev);
      end
      if (rvalid && rready) r_hs_cnt++;
      if (m_valid) mv_cnt++;
      check("s_ready_low_under_flush", {31'd0, s_ready & flush}, 32'd0);
      arv_prev    = arvalid;
      arr_prev    = arready;
      araddr_prev = araddr;
      if (arvalid && arready) ar_expected = 1'b0;
      if (s_valid && s_ready) begin
        check("single_entry", 32'(exp_q.size()), 32'd0);
        exp_q.push_back(predict(pc, slave_data, slave_resp));
        rd_data = slave_data;
        rd_resp = slave_resp;
        if (pc[1:0] == 2'b00) begin
          ar_expected = 1'b1;
          exp_araddr  = pc;
        end
        if (rand_mode) begin
          ar_wait = $urandom_range(0, 3);
          r_wait  = $urandom_range(0, 3);
        end
      end
    end
  end

  // ---------------- result monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_cnt = 32'd0;
    end else begin
      check("inst_cnt", inst_cnt, exp_cnt);
      check("inst_cnt_wrap_instance", w_inst_cnt, exp_cnt + 32'hFFFF_FFFF);
      check("m_valid_during_flush", {31'd0, m_valid & flush}, 32'd0);
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_m_valid", {31'd0, m_valid}, 32'd0);
        end else begin
          check("inst", inst, exp_q[0].inst);
          check("pc_out", pc_out, exp_q[0].pc);
          check("fetch_err", {31'd0, fetch_err}, {31'd0, exp_q[0].err});
        end
      end
      if (exp_q.size() > 0) begin
        if (flush) begin
          void'(exp_q.pop_front());
        end else if (m_valid && m_ready) begin
          void'(exp_q.pop_front());
          exp_cnt = exp_cnt + 32'd1;
        end
      end
    end
  end

  // ---------------- scenario helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and return one step after the accepting edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
    bit ok;
    ok = 1'b0;
    slave_data = d;
    slave_resp = r;
    pc         = a;
    s_valid    = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = s_ready;
      tick();
    end
    s_valid = 1'b0;
    if (!ok) fail("accept_timeout");
  endtask

  // Latency counted in edges from the accepting edge; returns at a negedge.
  task automatic wait_mvalid(output int lat);
    bit seen;
    seen = 1'b0;
    lat  = 1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (m_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
      lat++;
    end
    if (!seen) fail("m_valid_timeout");
  endtask

  task automatic release_out();
    tick();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, {31'd0, s_ready}, 32'd0);
    check({tag, "_arvalid"}, {31'd0, arvalid}, 32'd0);
    check({tag, "_rready"}, {31'd0, rready}, 32'd0);
    check({tag, "_m_valid"}, {31'd0, m_valid}, 32'd0);
    check({tag, "_inst"}, inst, 32'd0);
    check({tag, "_pc_out"}, pc_out, 32'd0);
    check({tag, "_araddr"}, araddr, 32'd0);
    check({tag, "_fetch_err"}, {31'd0, fetch_err}, 32'd0);
    check({tag, "_inst_cnt"}, inst_cnt, 32'd0);
    check({tag, "_w_inst_cnt"}, w_inst_cnt, 32'hFFFF_FFFF);
    check({tag, "_w_handshakes"}, {28'd0, w_s_ready, w_arvalid, w_rready, w_m_valid}, 32'd0);
    check({tag, "_w_regs"}, w_inst | w_pc_out | w_araddr | {31'd0, w_fetch_err}, 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scenarios ----------------
  initial begin
    int          lat;
    int          a0, r0, m0;
    logic [31:0] r32;

    // Reset state
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("s_ready_after_reset", {31'd0, s_ready}, 32'd1);

    // Basic fetch, minimum latency
    tick();
    issue(32'h8000_0000, 32'h0010_0073, 2'b00);
    wait_mvalid(lat);
    check("basic_latency", lat, 32'd3);
    check("basic_inst", inst, 32'h0010_0073);
    check("basic_pc_out", pc_out, 32'h8000_0000);
    check("basic_fetch_err", {31'd0, fetch_err}, 32'd0);
    release_out();
    @(negedge clk);
    check("basic_inst_cnt", inst_cnt, 32'd1);
    check("wrap_inst_cnt", w_inst_cnt, 32'd0);

    // Backpressure on both AR and downstream
    tick();
    ar_wait = 4;
    a0 = ar_cycles;
    issue(32'h8000_1000, 32'hCAFE_F00D, 2'b00);
    wait_mvalid(lat);
    check("bp_ar_cycles", ar_cycles - a0, 32'd5);
    check("bp_latency", lat, 32'd7);
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      check("bp_m_valid_held", {31'd0, m_valid}, 32'd1);
      check("bp_inst_held", inst, 32'hCAFE_F00D);
    end
    release_out();
    ar_wait = 0;
    repeat (2) tick();
    check("bp_inst_cnt_once", inst_cnt, 32'd2);

    // Bus error response
    issue(32'h8000_2000, 32'h1234_5678, 2'b10);
    wait_mvalid(lat);
    check("rresp_inst", inst, ERR_INST);
    check("rresp_fetch_err", {31'd0, fetch_err}, 32'd1);
    check("rresp_pc_out", pc_out, 32'h8000_2000);
    release_out();

    // Misaligned PC: no bus traffic
    tick();
    a0 = ar_cycles;
    issue(32'h8000_0002, 32'h1111_1111, 2'b00);
    wait_mvalid(lat);
    check("misaligned_latency", lat, 32'd1);
    check("misaligned_inst", inst, ERR_INST);
    check("misaligned_fetch_err", {31'd0, fetch_err}, 32'd1);
    check("misaligned_pc_out", pc_out, 32'h8000_0002);
    release_out();
    tick();
    check("misaligned_no_arvalid", ar_cycles - a0, 32'd0);
    check("misaligned_inst_cnt", inst_cnt, 32'd4);

    // Flush in R; rvalid arrives later and is drained
    r_wait = 2;
    r0 = r_hs_cnt;
    m0 = mv_cnt;
    issue(32'h8000_3000, 32'h2222_2222, 2'b00);
    tick();
    check("flush_r_in_r", {31'd0, rready}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (6) tick();
    check("flush_r_handshake", r_hs_cnt - r0, 32'd1);
    check("flush_r_no_m_valid", mv_cnt - m0, 32'd0);
    check("flush_r_idle", {31'd0, s_ready}, 32'd1);
    check("flush_r_inst_cnt", inst_cnt, 32'd4);
    r_wait = 0;

    // Flush in HOLD with m_ready high in the same cycle
    issue(32'h8000_4000, 32'hABCD_0001, 2'b00);
    wait_mvalid(lat);
    tick();
    flush   = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    check("flush_hold_m_valid_gated", {31'd0, m_valid}, 32'd0);
    tick();
    flush   = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
    check("flush_hold_idle", {31'd0, s_ready}, 32'd1);
    check("flush_hold_inst_cnt", inst_cnt, 32'd4);

    // Reset pulsed mid-R
    tick();
    r_wait = 20;
    issue(32'h8000_5000, 32'h3333_3333, 2'b00);
    tick();
    @(negedge clk);
    check("midr_in_r", {31'd0, rready}, 32'd1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midr_reset");
    repeat (2) tick();
    rst    = 1'b0;
    r_wait = 0;
    @(negedge clk);
    check("midr_s_ready_after_reset", {31'd0, s_ready}, 32'd1);

    // One fetch after reset: wrap instance goes 0xFFFF_FFFF -> 0
    tick();
    issue(32'h8000_6000, 32'h4444_4444, 2'b00);
    wait_mvalid(lat);
    release_out();
    @(negedge clk);
    check("wrap_after_reset_cnt", inst_cnt, 32'd1);
    check("wrap_after_reset_w_cnt", w_inst_cnt, 32'd0);

    // Randomized traffic
    rand_mode = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      r32        = $urandom;
      s_valid    = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 9) == 0)
        pc = {r32[31:2], 2'($urandom_range(1, 3))};
      else
        pc = {r32[31:2], 2'b00};
      slave_data = $urandom;
      slave_resp = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      flush      = ($urandom_range(0, 24) == 0);
      m_ready    = ($urandom_range(0, 1) == 1);
    end

    // Drain
    tick();
    rand_mode = 1'b0;
    s_valid   = 1'b0;
    flush     = 1'b0;
    m_ready   = 1'b1;
    ar_wait   = 0;
    r_wait    = 0;
    repeat (20) tick();
    @(negedge clk);
    check("drain_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("drain_idle", {31'd0, s_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifu_axi_fetch.md
IFU_AXI_FETCH -- requirements
Module: ifu_axi_fetch

Interface
REQ-001 SHALL have parameter RESET_CNT, default 0: reset value of the fetched-instruction counter.
REQ-002 SHALL have parameter ERR_INST, default 32'h0000_0000: instruction word emitted on any fetch error.
REQ-003 SHALL have a single clock and an asynchronous, active-high reset.
REQ-004 SHALL have port clk, input, 1: rising-edge clock.
REQ-005 SHALL have port rst, input, 1: asynchronous reset, active high.
REQ-006 SHALL have port s_valid, input, 1: upstream (PC) fetch request valid.
REQ-007 SHALL have port s_ready, output, 1: fetch request accepted this cycle when high with s_valid.
REQ-008 SHALL have port pc, input, 32: fetch address.
REQ-009 SHALL have port flush, input, 1: discard the in-flight or held fetch.
REQ-010 SHALL have port araddr, output, 32: AXI4-Lite read address.
REQ-011 SHALL have port arvalid, output, 1; port arready, input, 1.
REQ-012 SHALL have port rdata, input, 32; port rresp, input, 2; port rvalid, input, 1; port rready, output, 1.
REQ-013 SHALL have port m_valid, output, 1; port m_ready, input, 1: downstream (decode) handshake.
REQ-014 SHALL have port inst, output, 32; port pc_out, output, 32: fetched word and its address.
REQ-015 SHALL have port fetch_err, output, 1: held result is a bus error or misaligned fetch.
REQ-016 SHALL have port inst_cnt, output, 32: count of completed downstream handshakes.

Function
REQ-017 SHALL implement FSM states IDLE, AR, R, HOLD, all transitions on the rising edge of clk.
REQ-018 SHALL drive s_ready = (state==IDLE) & ~flush.
REQ-019 SHALL, in IDLE on s_valid & s_ready with pc[1:0]==0: latch pc into pc_q and go to AR.
REQ-020 SHALL, in IDLE on s_valid & s_ready with pc[1:0]!=0: latch pc, set inst=ERR_INST and fetch_err=1, go to HOLD, and issue no bus transaction.
REQ-021 SHALL, in AR: drive arvalid=1 and araddr=pc_q, both stable until arready, then go to R.
REQ-022 SHALL, in R: drive rready=1; on rvalid, latch rdata into inst and set fetch_err=(rresp!=0), then go to HOLD.
REQ-023 SHALL replace inst with ERR_INST when rresp!=0.
REQ-024 SHALL drive arvalid=0 outside AR and rready=0 outside R.
REQ-025 SHALL drive m_valid=1 only in HOLD with the flushed flag clear, holding inst, pc_out and fetch_err stable until m_ready.
REQ-026 SHALL, in HOLD on m_ready: go to IDLE and increment inst_cnt by 1 (modulo 2^32; 32'hFFFF_FFFF wraps to 0).
REQ-027 SHALL keep a one-entry pipeline: no new request is accepted while in AR, R or HOLD.
REQ-028 SHALL, on flush in AR or R: set the flushed flag, continue the AXI transaction to completion without ever dropping arvalid before arready, then go from R to IDLE without entering HOLD, and clear the flag.
REQ-029 SHALL, on flush in HOLD: go to IDLE next cycle with no downstream handshake and no inst_cnt change, even if m_ready is high in the same cycle.
REQ-030 SHALL, on flush in IDLE: block acceptance that cycle, with no other effect.
REQ-031 SHALL have a minimum latency from s_valid acceptance to m_valid of 3 cycles when arready and rvalid are each high in their first cycle.

Reset
REQ-032 SHALL, on rst asserted at any time including mid-transaction, immediately force: state=IDLE, arvalid=0, rready=0, m_valid=0, s_ready=0 while rst is high, inst=0, pc_out=0, fetch_err=0, flushed=0, inst_cnt=RESET_CNT.
REQ-033 SHALL assert s_ready on the first rising edge after rst deasserts, provided flush is low.

Verification
REQ-034 SHALL test basic fetch: pc=0x8000_0000, arready=1, rvalid=1 with rdata=0x0010_0073 and rresp=0 -> m_valid at cycle 3, inst=0x0010_0073, pc_out=0x8000_0000, fetch_err=0, inst_cnt=1 after m_ready.
REQ-035 SHALL test backpressure: arready delayed 4 cycles, then m_ready low for 5 cycles -> araddr and arvalid stable throughout, inst stable throughout, exactly one increment of inst_cnt.
REQ-036 SHALL test errors: rresp=2'b10 -> inst=ERR_INST and fetch_err=1; pc=0x8000_0002 -> no arvalid ever asserted, fetch_err=1 in HOLD.
REQ-037 SHALL test flush in R with rvalid arriving 2 cycles later -> rready handshake completes, m_valid never rises, state returns to IDLE, inst_cnt unchanged.
REQ-038 SHALL test reset mid-R and counter wrap: rst pulsed mid-R -> arvalid, rready and m_valid are 0 immediately; with RESET_CNT=32'hFFFF_FFFF, one fetch -> inst_cnt=0.
